// File: rtl/instr_mem_if.sv
// Fetch-side bus between a requester (core or boot loader) and instr_mem_responder.
// Carries the fetch handshake, the response and the array load side port.
interface instr_mem_if;
   logic        req;
   logic [31:0] pc_in;
   logic        ready;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fault;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;

   modport master (
      output req, pc_in, ld_en, ld_addr, ld_data,
      input  ready, instr, instr_valid, fault
   );

   modport slave (
      input  req, pc_in, ld_en, ld_addr, ld_data,
      output ready, instr, instr_valid, fault
   );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: one outstanding fetch, WAIT_STATES+1 cycle latency.
// Optional next-word prefetch buffer enabled with `define IMEM_PREFETCH_EN.
module instr_mem_responder #(
   parameter int          AW          = 8,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
   input logic        clk,
   input logic        rst,
   instr_mem_if.slave bus
);

   if (WAIT_STATES > 15 || WAIT_STATES < 0) begin : g_ws_bad
      $error("instr_mem_responder: WAIT_STATES must be 0..15");
   end

   localparam logic [3:0] WLAST =
      4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        vld_q;
   logic        flt_q;

   logic [31:0] mem_q [2**AW];

   logic [AW-1:0] ld_idx;
   logic [AW-1:0] pc_idx;
   logic          pc_bad;
   logic          unused_ok;

   function automatic logic oob(input logic [31:0] a);
      oob = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
   endfunction

   assign ld_idx    = bus.ld_addr[AW+1:2];
   assign pc_idx    = pc_q[AW+1:2];
   assign pc_bad    = oob(pc_q);
   assign unused_ok = ^{bus.ld_addr[31:AW+2], bus.ld_addr[1:0]};

   // Array has no reset; NBA write gives old-data on a same-edge read.
   always_ff @(posedge clk) begin
      if (bus.ld_en) begin
         mem_q[ld_idx] <= bus.ld_data;
      end
   end

`ifdef IMEM_PREFETCH_EN
   logic          pf_valid_q;
   logic [31:0]   pf_addr_q;
   logic [31:0]   pf_data_q;
   logic          hit_q;
   logic [31:0]   nxt_pc;
   logic [AW-1:0] nxt_idx;
   logic          pf_upd;

   assign nxt_pc  = pc_q + 32'd4;
   assign nxt_idx = nxt_pc[AW+1:2];
   assign pf_upd  = (state_q == S_RESP) && !pc_bad;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         pc_q       <= 32'd0;
         instr_q    <= 32'd0;
         vld_q      <= 1'b0;
         flt_q      <= 1'b0;
`ifdef IMEM_PREFETCH_EN
         pf_valid_q <= 1'b0;
         pf_addr_q  <= 32'd0;
         pf_data_q  <= 32'd0;
         hit_q      <= 1'b0;
`endif
      end else begin
         vld_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.req) begin
                  pc_q  <= bus.pc_in;
                  cnt_q <= 4'd0;
`ifdef IMEM_PREFETCH_EN
                  if (pf_valid_q && bus.pc_in == pf_addr_q) begin
                     hit_q   <= 1'b1;
                     state_q <= S_RESP;
                  end else begin
                     hit_q      <= 1'b0;
                     pf_valid_q <= 1'b0;
                     state_q    <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                  end
`else
                  state_q <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
`endif
               end
            end
            S_WAIT: begin
               if (cnt_q == WLAST) begin
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            S_RESP: begin
               vld_q   <= 1'b1;
               flt_q   <= pc_bad;
               state_q <= S_IDLE;
               if (pc_bad) begin
                  instr_q <= NOP_WORD;
               end else begin
`ifdef IMEM_PREFETCH_EN
                  instr_q    <= (hit_q && pf_valid_q) ? pf_data_q
                                                      : mem_q[pc_idx];
                  pf_addr_q  <= nxt_pc;
                  pf_data_q  <= mem_q[nxt_idx];
                  pf_valid_q <= !oob(nxt_pc) &&
                                !(bus.ld_en && ld_idx == nxt_idx);
`else
                  instr_q <= mem_q[pc_idx];
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
`ifdef IMEM_PREFETCH_EN
         // A load to the buffered word makes the copy stale.
         if (bus.ld_en && !pf_upd &&
             ld_idx == pf_addr_q[AW+1:2]) begin
            pf_valid_q <= 1'b0;
         end
`endif
      end
   end

   assign bus.ready       = (state_q == S_IDLE);
   assign bus.instr       = instr_q;
   assign bus.instr_valid = vld_q;
   assign bus.fault       = flt_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized bench for instr_mem_responder against a word-array reference model.
// Build with +define+IMEM_PREFETCH_EN to cover the prefetch variant.
module tb_instr_mem_responder;
   localparam int          AW  = 8;
   localparam int          WS  = 2;
   localparam logic [31:0] NOP = 32'h0000_0000;
   localparam int          NW  = 2**AW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_mem_if bus();

   instr_mem_responder #(
      .AW(AW), .WAIT_STATES(WS), .NOP_WORD(NOP)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int n_chk = 0;
   int n_ok  = 0;

   logic [31:0] mm [NW];
   bit          pf_ok;
   logic [31:0] pf_pc;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_ok++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic bit bad(input logic [31:0] pc);
      return (pc % 4 != 0) || (pc >= 32'(4 * NW));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a / 4) % NW);
   endfunction

   function automatic bit pf_hit(input logic [31:0] pc);
`ifdef IMEM_PREFETCH_EN
      return pf_ok && pc == pf_pc;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int lat_of(input logic [31:0] pc);
      return pf_hit(pc) ? 1 : WS + 1;
   endfunction

   // Model of one accepted fetch: expected response plus next-word buffer.
   task automatic model_fetch(input  logic [31:0] pc,
                              output int          lat,
                              output logic [31:0] ei,
                              output logic        ef);
      lat = lat_of(pc);
      if (!pf_hit(pc)) pf_ok = 1'b0;
      ef = bad(pc);
      ei = ef ? NOP : mm[widx(pc)];
      if (!ef) begin
         pf_pc = pc + 4;
         pf_ok = !bad(pc + 4);
      end
   endtask

   task automatic model_load(input logic [31:0] a, input logic [31:0] d);
      mm[widx(a)] = d;
      if (pf_ok && widx(a) == widx(pf_pc)) pf_ok = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      bus.ld_en   = 1'b1;
      bus.ld_addr = a;
      bus.ld_data = d;
      tick;
      bus.ld_en = 1'b0;
      model_load(a, d);
   endtask

   task automatic fetch(input logic [31:0] pc,
                        input bit          do_ld,
                        input logic [31:0] la,
                        input logic [31:0] ld);
      int          lat;
      int          cyc;
      logic [31:0] ei;
      logic        ef;
      cyc = 0;
      while (!bus.ready && cyc < 20) begin
         tick;
         cyc++;
      end
      check("ready_idle", 32'(bus.ready), 32'd1);
      model_fetch(pc, lat, ei, ef);
      bus.req   = 1'b1;
      bus.pc_in = pc;
      tick;
      bus.req   = 1'b0;
      bus.pc_in = $urandom;
      check("ready_busy", 32'(bus.ready), 32'd0);
      cyc = 0;
      while (!bus.instr_valid && cyc < 20) begin
         if (do_ld && cyc == lat - 1) begin
            bus.ld_en   = 1'b1;
            bus.ld_addr = la;
            bus.ld_data = ld;
         end
         tick;
         if (do_ld && cyc == lat - 1) begin
            bus.ld_en = 1'b0;
            model_load(la, ld);
         end
         cyc++;
      end
      check("latency", 32'(cyc), 32'(lat));
      check("instr", bus.instr, ei);
      check("fault", 32'(bus.fault), 32'(ef));
      tick;
      check("valid_1cyc", 32'(bus.instr_valid), 32'd0);
      check("instr_hold", bus.instr, ei);
   endtask

   initial begin
      logic [31:0] pcs [3];
      logic [31:0] expq [$];
      int          dueq [$];
      int          n, got, cyc, lat, last, seen;
      bit          acc;
      logic [31:0] ei;
      logic        ef;

      bus.req     = 1'b0;
      bus.pc_in   = 32'd0;
      bus.ld_en   = 1'b0;
      bus.ld_addr = 32'd0;
      bus.ld_data = 32'd0;
      pf_ok       = 1'b0;
      pf_pc       = 32'd0;
      for (int i = 0; i < NW; i++) mm[i] = 32'd0;

      rst = 1'b1;
      #2;
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_instr", bus.instr, 32'd0);
      check("rst_fault", 32'(bus.fault), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NW; i++) load(32'(4 * i), $urandom);

      load(32'h0, 32'h2008_0005);
      load(32'h4, 32'h2009_0007);
      load(32'h8, 32'h0109_5020);
      load(32'hC, 32'hAC0A_0000);
      fetch(32'h0, 1'b0, 32'h0, 32'h0);
      fetch(32'h6, 1'b0, 32'h0, 32'h0);
      fetch(32'h400, 1'b0, 32'h0, 32'h0);

      // Reset during WAIT drops the fetch.
      bus.req   = 1'b1;
      bus.pc_in = 32'h4;
      tick;
      bus.req = 1'b0;
      tick;
      rst = 1'b1;
      #1;
      pf_ok = 1'b0;
      check("midrst_ready", 32'(bus.ready), 32'd1);
      check("midrst_instr", bus.instr, 32'd0);
      check("midrst_valid", 32'(bus.instr_valid), 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (bus.instr_valid) seen++;
      end
      check("midrst_noresp", 32'(seen), 32'd0);

      fetch(32'h8, 1'b1, 32'h8, 32'hDEAD_BEEF);
      fetch(32'h8, 1'b0, 32'h0, 32'h0);

      fetch(32'h0, 1'b0, 32'h0, 32'h0);
      fetch(32'h4, 1'b0, 32'h0, 32'h0);
      load(32'h8, 32'h1234_5678);
      fetch(32'h8, 1'b0, 32'h0, 32'h0);
      fetch(32'hC, 1'b0, 32'h0, 32'h0);

      // Back-to-back with req held; stray pc values while busy.
      pcs  = '{32'h0, 32'h4, 32'h8};
      n    = 0;
      got  = 0;
      cyc  = 0;
      last = 0;
      bus.req = 1'b1;
      while (got < 3 && cyc < 60) begin
         acc = bus.ready && n < 3;
         if (acc) bus.pc_in = pcs[n];
         else bus.pc_in = $urandom;
         if (bus.ready && n >= 3) bus.req = 1'b0;
         tick;
         cyc++;
         if (acc) begin
            model_fetch(pcs[n], lat, ei, ef);
            expq.push_back(ei);
            dueq.push_back(cyc + lat);
            n++;
         end
         if (bus.instr_valid) begin
            check("b2b_time", 32'(cyc), 32'(dueq.pop_front()));
            check("b2b_instr", bus.instr, expq.pop_front());
`ifndef IMEM_PREFETCH_EN
            if (got > 0) check("b2b_gap", 32'(cyc - last), 32'(WS + 2));
`endif
            last = cyc;
            got++;
         end
      end
      bus.req = 1'b0;
      check("b2b_count", 32'(got), 32'd3);
      tick;

      for (int it = 0; it < 60; it++) begin
         logic [31:0] pc;
         int          sel;
         sel = int'($urandom_range(0, 9));
         if (sel < 6) pc = {22'd0, 8'($urandom_range(0, NW - 1)), 2'b00};
         else if (sel < 8) pc = pf_pc;
         else pc = $urandom;
         if (sel == 9) load($urandom, $urandom);
         fetch(pc, $urandom_range(0, 3) == 0, $urandom, $urandom);
      end

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end
endmodule
